// File: rtl/quadrature_decoder.sv
// Quadrature encoder front end: synchronizes A/B, filters the AB pair as one vector,
// and emits registered step/direction and illegal-transition pulses.
module quadrature_decoder #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       a_in,
   input  logic       b_in,
   input  logic       clear_err,
   output logic       step,
   output logic       up_down,
   output logic       error,
   output logic [7:0] err_count,
   output logic [1:0] ab_state
);

   localparam logic [4:0] FILT_TC = 5'(FILTER_CYCLES);

   logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
   logic [1:0]             s_ab;
   logic [1:0]             prev_q;
   logic [3:0]             cnt_q, cnt_d;
   logic [4:0]             cnt_inc;
   logic [1:0]             ab_q, ab_d;
   logic                   first_q, first_d;
   logic                   step_q, step_d;
   logic                   error_q, error_d;
   logic                   up_q, up_d;
   logic [7:0]             errc_q, errc_d;
   logic [1:0]             delta;
   logic                   accept;

   // Position along the forward cycle 00->01->11->10 -> 0,1,2,3.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   assign s_ab    = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
   assign cnt_inc = {1'b0, cnt_q} + 5'd1;
   assign delta   = gray_pos(s_ab) - gray_pos(ab_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a_q <= '0;
         sync_b_q <= '0;
         prev_q   <= 2'b00;
         cnt_q    <= 4'd0;
         ab_q     <= 2'b00;
         first_q  <= 1'b1;
         step_q   <= 1'b0;
         error_q  <= 1'b0;
         up_q     <= 1'b1;
         errc_q   <= 8'd0;
      end else begin
         sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], a_in};
         sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], b_in};
         prev_q   <= s_ab;
         cnt_q    <= cnt_d;
         ab_q     <= ab_d;
         first_q  <= first_d;
         step_q   <= step_d;
         error_q  <= error_d;
         up_q     <= up_d;
         errc_q   <= errc_d;
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      ab_d    = ab_q;
      first_d = first_q;
      step_d  = 1'b0;
      error_d = 1'b0;
      up_d    = up_q;
      errc_d  = errc_q;
      accept  = 1'b0;

      // Until the first value is accepted ab_q is not meaningful, so equality does not hold off the filter.
      if (((s_ab == ab_q) && !first_q) || (s_ab != prev_q)) begin
         cnt_d = 4'd0;
      end else if (cnt_inc == FILT_TC) begin
         accept = 1'b1;
         cnt_d  = 4'd0;
      end else begin
         cnt_d = cnt_inc[3:0];
      end

      if (accept) begin
         ab_d    = s_ab;
         first_d = 1'b0;
         if (!first_q && enable) begin
            case (delta)
               2'd1: begin
                  step_d = 1'b1;
                  up_d   = 1'b1;
               end
               2'd3: begin
                  step_d = 1'b1;
                  up_d   = 1'b0;
               end
               2'd2:    error_d = 1'b1;
               default: ;
            endcase
         end
      end

      if (clear_err) begin
         errc_d = 8'd0;
      end else if (error_d && (errc_q != 8'hFF)) begin
         errc_d = errc_q + 8'd1;
      end
   end

   assign step      = step_q;
   assign error     = error_q;
   assign up_down   = up_q;
   assign err_count = errc_q;
   assign ab_state  = ab_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder at default parameters (pulse lands 6 edges after the sampling edge,
// i.e. on the 7th rising edge counted from the input change).
module tb_quadrature_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       a_in;
   logic       b_in;
   logic       clear_err;
   logic       step;
   logic       up_down;
   logic       error;
   logic [7:0] err_count;
   logic [1:0] ab_state;

   int checks = 0;
   int errors = 0;

   quadrature_decoder dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .a_in      (a_in),
      .b_in      (b_in),
      .clear_err (clear_err),
      .step      (step),
      .up_down   (up_down),
      .error     (error),
      .err_count (err_count),
      .ab_state  (ab_state)
   );

   always #5 clk = ~clk;

   task automatic drive_ab(input logic [1:0] ab);
      @(negedge clk);
      a_in = ab[1];
      b_in = ab[0];
   endtask

   task automatic watch(input int ncyc, output int n_step, output int n_err, output int pulse_cyc,
                        output logic dir, output int n_both);
      n_step    = 0;
      n_err     = 0;
      n_both    = 0;
      pulse_cyc = -1;
      dir       = 1'bx;
      for (int i = 1; i <= ncyc; i++) begin
         @(posedge clk);
         #1;
         if (step) begin
            n_step++;
            pulse_cyc = i;
            dir       = up_down;
         end
         if (error) begin
            n_err++;
            pulse_cyc = i;
         end
         if (step && error) n_both++;
      end
   endtask

   task automatic test_reset();
      int ns, ne, pc, nb;
      logic d;
      reset = 1'b1; enable = 1'b1; clear_err = 1'b0; a_in = 1'b1; b_in = 1'b1;
      #2;
      checks++;
      if ({step, up_down, error, err_count, ab_state} !== {1'b0, 1'b1, 1'b0, 8'd0, 2'b00}) begin
         errors++;
         $display("FAIL reset_outputs: got step=%b up=%b err=%b cnt=%0d ab=%b, expected 0 1 0 0 00",
                  step, up_down, error, err_count, ab_state);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      watch(7, ns, ne, pc, d, nb);
      checks++;
      if (ab_state !== 2'b11) begin
         errors++; $display("FAIL reset_first_ab: got %b expected 11", ab_state);
      end
      watch(3, ns, ne, pc, d, nb);
      checks++;
      if (ns !== 0 || ne !== 0 || err_count !== 8'd0) begin
         errors++; $display("FAIL reset_first_silent: steps=%0d errs=%0d cnt=%0d expected 0 0 0", ns, ne, err_count);
      end
   endtask

   task automatic test_forward();
      logic [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
      int ns, ne, pc, nb;
      logic d;
      reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      watch(10, ns, ne, pc, d, nb);
      for (int k = 0; k < 4; k++) begin
         drive_ab(seq[k]);
         watch(10, ns, ne, pc, d, nb);
         checks++;
         if (ns !== 1 || ne !== 0) begin
            errors++; $display("FAIL fwd_pulses edge %0d: steps=%0d errs=%0d expected 1 0", k, ns, ne);
         end
         checks++;
         if (pc !== 7) begin
            errors++; $display("FAIL fwd_latency edge %0d: pulse on edge %0d expected 7", k, pc);
         end
         checks++;
         if (d !== 1'b1 || ab_state !== seq[k]) begin
            errors++; $display("FAIL fwd_dir_ab edge %0d: up=%b ab=%b expected 1 %b", k, d, ab_state, seq[k]);
         end
      end
   endtask

   task automatic test_reverse();
      logic [1:0] seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
      int ns, ne, pc, nb, tot_step, bad;
      logic d;
      logic ab_moved;
      tot_step = 0;
      bad      = 0;
      for (int k = 0; k < 8; k++) begin
         drive_ab(seq[k % 4]);
         watch(10, ns, ne, pc, d, nb);
         tot_step += ns;
         if (ns != 1 || ne != 0 || d !== 1'b0 || pc != 7 || ab_state !== seq[k % 4]) bad++;
      end
      checks++;
      if (tot_step !== 8 || bad !== 0) begin
         errors++; $display("FAIL rev_steps: steps=%0d bad_edges=%0d expected 8 0", tot_step, bad);
      end
      ns = 0; ne = 0; ab_moved = 1'b0;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         a_in = (i < 3);
         @(posedge clk);
         #1;
         if (step) ns++;
         if (error) ne++;
         if (ab_state !== 2'b00) ab_moved = 1'b1;
      end
      checks++;
      if (ns !== 0 || ne !== 0) begin
         errors++; $display("FAIL glitch_pulses: steps=%0d errs=%0d expected 0 0", ns, ne);
      end
      checks++;
      if (ab_moved !== 1'b0 || up_down !== 1'b0) begin
         errors++; $display("FAIL glitch_state: ab_moved=%b up=%b expected 0 0", ab_moved, up_down);
      end
   endtask

   task automatic test_errors();
      int n_err, n_step, bad_lat;
      n_err = 0; n_step = 0; bad_lat = 0;
      for (int k = 1; k <= 360; k++) begin
         drive_ab((k % 2 == 1) ? 2'b11 : 2'b00);
         for (int i = 1; i <= 8; i++) begin
            if (k == 101 && i == 7) clear_err = 1'b1;
            @(posedge clk);
            #1;
            clear_err = 1'b0;
            if (error) begin
               if (k <= 300) n_err++;
               if (i != 7) bad_lat++;
            end
            if (step) n_step++;
            if (k == 101 && i == 7) begin
               checks++;
               if (error !== 1'b1 || err_count !== 8'd0) begin
                  errors++; $display("FAIL clear_priority: err=%b cnt=%0d expected 1 0", error, err_count);
               end
            end
         end
         if (k == 100) begin
            checks++;
            if (err_count !== 8'd100) begin
               errors++; $display("FAIL err_count_100: got %0d expected 100", err_count);
            end
         end
         if (k == 300) begin
            checks++;
            if (n_err !== 300 || err_count !== 8'd199) begin
               errors++; $display("FAIL err_300: pulses=%0d cnt=%0d expected 300 199", n_err, err_count);
            end
         end
         if (k == 356) begin
            checks++;
            if (err_count !== 8'd255) begin
               errors++; $display("FAIL err_sat_reach: got %0d expected 255", err_count);
            end
         end
      end
      checks++;
      if (err_count !== 8'd255) begin
         errors++; $display("FAIL err_sat_hold: got %0d expected 255", err_count);
      end
      checks++;
      if (n_step !== 0 || bad_lat !== 0 || up_down !== 1'b0) begin
         errors++; $display("FAIL err_side: steps=%0d bad_latency=%0d up=%b expected 0 0 0", n_step, bad_lat, up_down);
      end
   endtask

   task automatic test_disable();
      logic [1:0] seq [3] = '{2'b01, 2'b11, 2'b10};
      int ns, ne, pc, nb;
      logic d;
      @(negedge clk);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_ab(seq[k]);
         watch(10, ns, ne, pc, d, nb);
         checks++;
         if (ns !== 0 || ne !== 0 || ab_state !== seq[k] || up_down !== 1'b0) begin
            errors++; $display("FAIL disabled_edge %0d: steps=%0d errs=%0d ab=%b up=%b expected 0 0 %b 0",
                               k, ns, ne, ab_state, up_down, seq[k]);
         end
      end
      @(negedge clk);
      enable = 1'b1;
      drive_ab(2'b11);
      watch(10, ns, ne, pc, d, nb);
      checks++;
      if (ns !== 1 || ne !== 0 || d !== 1'b0 || pc !== 7 || ab_state !== 2'b11 || err_count !== 8'd255) begin
         errors++; $display("FAIL reenable_rev: steps=%0d errs=%0d up=%b edge=%0d ab=%b cnt=%0d expected 1 0 0 7 11 255",
                            ns, ne, d, pc, ab_state, err_count);
      end
   endtask

   task automatic test_reset_mid();
      int ns, ne, pc, nb;
      logic d;
      drive_ab(2'b01);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({step, up_down, error, err_count, ab_state} !== {1'b0, 1'b1, 1'b0, 8'd0, 2'b00}) begin
         errors++; $display("FAIL midreset_async: got step=%b up=%b err=%b cnt=%0d ab=%b, expected 0 1 0 0 00",
                            step, up_down, error, err_count, ab_state);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      watch(12, ns, ne, pc, d, nb);
      checks++;
      if (ns !== 0 || ne !== 0 || nb !== 0) begin
         errors++; $display("FAIL midreset_pulses: steps=%0d errs=%0d expected 0 0", ns, ne);
      end
      checks++;
      if (ab_state !== 2'b01 || up_down !== 1'b1 || err_count !== 8'd0) begin
         errors++; $display("FAIL midreset_state: ab=%b up=%b cnt=%0d expected 01 1 0", ab_state, up_down, err_count);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_errors();
      test_disable();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
